// File: rtl/serv_ram32_arbiter_if.sv
// SERV-side instruction and data bus bundle between the core (master)
// and the RAM32 arbiter (slave).
interface serv_ram32_arbiter_if;
  logic        ibus_cyc;
  logic [31:0] ibus_adr;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic        dbus_cyc;
  logic [31:0] dbus_adr;
  logic        dbus_we;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;

  modport master (
    output ibus_cyc, ibus_adr, dbus_cyc, dbus_adr, dbus_we, dbus_dat, dbus_sel,
    input  ibus_rdt, ibus_ack, dbus_rdt, dbus_ack
  );

  modport slave (
    input  ibus_cyc, ibus_adr, dbus_cyc, dbus_adr, dbus_we, dbus_dat, dbus_sel,
    output ibus_rdt, ibus_ack, dbus_rdt, dbus_ack
  );
endinterface

// File: rtl/serv_ram32_arbiter.sv
// Merges SERV ibus/dbus onto one RAM32 port (dbus priority), returns RAM-timed
// acks and read data, decodes the RAM window and counts out-of-window accesses.
module serv_ram32_arbiter #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned AW        = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serv_ram32_arbiter_if.slave  bus,
  output logic                 ram_en,
  output logic [AW-1:0]        ram_a,
  output logic [3:0]           ram_we,
  output logic [31:0]          ram_di,
  input  logic [31:0]          ram_do,
  output logic [7:0]           err_cnt
);

  typedef enum logic {IDLE, RESP} state_t;

  // Bits above the word index form the tag that must match the window base.
  localparam logic [31:0] TAG_MASK = ~((32'd1 << (AW + 2)) - 32'd1);

  state_t      state;
  state_t      state_nxt;
  logic        gnt;
  logic        hit;
  logic        wr;
  logic        req;
  logic        req_gnt;
  logic        req_hit;
  logic [31:0] req_adr;

  assign req     = bus.dbus_cyc | bus.ibus_cyc;
  assign req_gnt = bus.dbus_cyc;
  assign req_adr = req_gnt ? bus.dbus_adr : bus.ibus_adr;
  assign req_hit = ((req_adr ^ ADDR_BASE) & TAG_MASK) == 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The write flag is kept so a write ack never forwards stale RAM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= 1'b0;
      hit <= 1'b0;
      wr  <= 1'b0;
    end else if (state == IDLE && req) begin
      gnt <= req_gnt;
      hit <= req_hit;
      wr  <= req_gnt & bus.dbus_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'h00;
    end else if (state == IDLE && req && !req_hit && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  // rst_n gates the enables directly so the RAM is quiet during reset.
  always_comb begin
    ram_a        = req_adr[AW+1:2];
    ram_di       = bus.dbus_dat;
    ram_en       = 1'b0;
    ram_we       = 4'b0000;
    bus.ibus_ack = 1'b0;
    bus.ibus_rdt = 32'h0;
    bus.dbus_ack = 1'b0;
    bus.dbus_rdt = 32'h0;
    if (rst_n && state == IDLE && req && req_hit) begin
      ram_en = 1'b1;
      if (req_gnt && bus.dbus_we) ram_we = bus.dbus_sel;
    end
    if (state == RESP) begin
      if (gnt) begin
        bus.dbus_ack = bus.dbus_cyc;
        if (bus.dbus_cyc && hit && !wr) bus.dbus_rdt = ram_do;
      end else begin
        bus.ibus_ack = bus.ibus_cyc;
        if (bus.ibus_cyc && hit) bus.ibus_rdt = ram_do;
      end
    end
  end

endmodule
